// File: rtl/secded_dec_pipe.sv
// Two-stage pipelined Hsiao SECDED decoder with valid/ready handshake and a global stall.
// Optional error statistics (counters + first-DBL syndrome capture) built when SECDED_ERRCNT_EN is defined.
module secded_dec_pipe #(
    parameter int DW   = 32,
    parameter int PW   = 7,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [DW+PW-1:0]   in,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [DW-1:0]      finout,
    output logic [PW-1:0]      syn,
    output logic               err,
    output logic               sgl,
    output logic               dbl,
    input  logic               cnt_clr,
    output logic [CNTW-1:0]    sgl_cnt,
    output logic [CNTW-1:0]    dbl_cnt,
    output logic [PW-1:0]      dbl_syn
);

    function automatic int count_cols();
        int n;
        n = 0;
        for (int v = 0; v < (1 << PW); v++) begin
            if (($countones(v) % 2 == 1) && ($countones(v) >= 3)) begin
                n++;
            end
        end
        return n;
    endfunction

    // Data columns: odd weight >= 3, grouped by weight, ascending value within a weight.
    function automatic logic [DW*PW-1:0] build_cols();
        logic [DW*PW-1:0] c;
        int n;
        c = '0;
        n = 0;
        for (int w = 3; w <= PW; w += 2) begin
            for (int v = 0; v < (1 << PW); v++) begin
                if (($countones(v) == w) && (n < DW)) begin
                    c[n*PW +: PW] = v[PW-1:0];
                    n++;
                end
            end
        end
        return c;
    endfunction

    localparam int               NCOLS = count_cols();
    localparam logic [DW*PW-1:0] HCOLS = build_cols();

    generate
        if (NCOLS < DW) begin : g_bad_width
            $error("secded_dec_pipe: PW=%0d has only %0d usable columns for DW=%0d", PW, NCOLS, DW);
        end
    endgenerate

    logic en;
    assign en     = !out_vld || out_rdy;
    assign in_rdy = en;

    // ---------------- stage 1: syndrome ----------------
    logic [PW-1:0] in_syn;

    always_comb begin
        in_syn = in[DW +: PW];
        for (int i = 0; i < DW; i++) begin
            if (in[i]) begin
                in_syn = in_syn ^ HCOLS[i*PW +: PW];
            end
        end
    end

    logic          s1_vld_reg;
    logic [DW-1:0] s1_data_reg;
    logic [PW-1:0] s1_syn_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_reg  <= 1'b0;
            s1_data_reg <= '0;
            s1_syn_reg  <= '0;
        end else if (en) begin
            s1_vld_reg <= in_vld;
            if (in_vld) begin
                s1_data_reg <= in[DW-1:0];
                s1_syn_reg  <= in_syn;
            end
        end
    end

    // ---------------- stage 2: classify and correct ----------------
    logic [DW-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_match
            assign match[gi] = (s1_syn_reg == HCOLS[gi*PW +: PW]);
        end
    endgenerate

    logic          is_onehot;
    logic          sgl_next;
    logic          dbl_next;
    logic [DW-1:0] fix_next;

    always_comb begin
        is_onehot = $onehot(s1_syn_reg);
        sgl_next  = (|match) || is_onehot;
        dbl_next  = (s1_syn_reg != '0) && !sgl_next;
        // match is all-zero for clean, check-bit and uncorrectable words
        fix_next  = s1_data_reg ^ match;
    end

    logic          out_vld_reg;
    logic [DW-1:0] finout_reg;
    logic [PW-1:0] syn_reg;
    logic          err_reg;
    logic          sgl_reg;
    logic          dbl_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_reg <= 1'b0;
            finout_reg  <= '0;
            syn_reg     <= '0;
            err_reg     <= 1'b0;
            sgl_reg     <= 1'b0;
            dbl_reg     <= 1'b0;
        end else if (en) begin
            out_vld_reg <= s1_vld_reg;
            if (s1_vld_reg) begin
                finout_reg <= fix_next;
                syn_reg    <= s1_syn_reg;
                err_reg    <= sgl_next || dbl_next;
                sgl_reg    <= sgl_next;
                dbl_reg    <= dbl_next;
            end
        end
    end

    assign out_vld = out_vld_reg;
    assign finout  = finout_reg;
    assign syn     = syn_reg;
    assign err     = err_reg;
    assign sgl     = sgl_reg;
    assign dbl     = dbl_reg;

    // ---------------- error statistics ----------------
`ifdef SECDED_ERRCNT_EN
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic            out_hs;
    logic [CNTW-1:0] sgl_cnt_reg;
    logic [CNTW-1:0] dbl_cnt_reg;
    logic [PW-1:0]   dbl_syn_reg;
    logic            dbl_loaded_reg;

    assign out_hs = out_vld_reg && out_rdy;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sgl_cnt_reg    <= '0;
            dbl_cnt_reg    <= '0;
            dbl_syn_reg    <= '0;
            dbl_loaded_reg <= 1'b0;
        end else if (out_hs) begin
            if (sgl_reg && (sgl_cnt_reg != CNT_MAX)) begin
                sgl_cnt_reg <= sgl_cnt_reg + CNTW'(1);
            end
            if (dbl_reg && (dbl_cnt_reg != CNT_MAX)) begin
                dbl_cnt_reg <= dbl_cnt_reg + CNTW'(1);
            end
            if (dbl_reg && !dbl_loaded_reg) begin
                dbl_syn_reg    <= syn_reg;
                dbl_loaded_reg <= 1'b1;
            end
        end
    end

    assign sgl_cnt = sgl_cnt_reg;
    assign dbl_cnt = dbl_cnt_reg;
    assign dbl_syn = dbl_syn_reg;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign sgl_cnt        = '0;
    assign dbl_cnt        = '0;
    assign dbl_syn        = '0;
`endif

endmodule

// File: tb/tb_secded_dec_pipe.sv
// Randomised and directed bench for secded_dec_pipe against a code-table reference model.
// A second instance with CNTW=2 exercises counter saturation.
module tb_secded_dec_pipe;

    localparam int DW = 32;
    localparam int PW = 7;
`ifdef SECDED_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          in_vld = 1'b0;
    logic          out_rdy = 1'b1;
    logic          cnt_clr = 1'b0;
    logic [38:0]   in_cw = '0;

    logic          in_rdy, out_vld, err, sgl, dbl;
    logic [31:0]   finout;
    logic [6:0]    syn, dbl_syn;
    logic [15:0]   sgl_cnt, dbl_cnt;

    logic          in_rdy2, out_vld2, err2, sgl2, dbl2;
    logic [31:0]   finout2;
    logic [6:0]    syn2, dbl_syn2;
    logic [1:0]    sgl_cnt2, dbl_cnt2;

    secded_dec_pipe #(.DW(DW), .PW(PW), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in(in_cw),
        .out_vld(out_vld), .out_rdy(out_rdy), .finout(finout), .syn(syn),
        .err(err), .sgl(sgl), .dbl(dbl), .cnt_clr(cnt_clr),
        .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt), .dbl_syn(dbl_syn)
    );

    secded_dec_pipe #(.DW(DW), .PW(PW), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy2), .in(in_cw),
        .out_vld(out_vld2), .out_rdy(out_rdy), .finout(finout2), .syn(syn2),
        .err(err2), .sgl(sgl2), .dbl(dbl2), .cnt_clr(cnt_clr),
        .sgl_cnt(sgl_cnt2), .dbl_cnt(dbl_cnt2), .dbl_syn(dbl_syn2)
    );

    typedef struct {
        logic [31:0] data;
        logic [6:0]  syn;
        bit          sgl;
        bit          dbl;
    } item_t;

    item_t       q[$];
    logic [6:0]  cols [32];
    int          checks = 0;
    int          failures = 0;

    // model statistics
    int          m_sgl, m_dbl, m2_sgl, m2_dbl;
    logic [6:0]  m_dsyn;
    bit          m_dload;

    // values sampled by tick()
    bit          s_in_rdy, s_out_vld, s_err, s_sgl, s_dbl, s_out_hs, s_in_hs, s_q_empty;
    logic [31:0] s_finout;
    logic [6:0]  s_syn, s_dbl_syn;
    logic [15:0] s_sgl_cnt, s_dbl_cnt;
    logic [1:0]  s2_sgl_cnt;
    int          e_sgl, e_dbl, e2_sgl;
    logic [6:0]  e_dsyn;
    item_t       s_exp;

    function automatic void build_model();
        int n;
        n = 0;
        for (int w = 3; w <= 7; w += 2)
            for (int v = 0; v < 128; v++)
                if ($countones(v) == w && n < 32) begin
                    cols[n] = v[6:0];
                    n++;
                end
    endfunction

    function automatic logic [6:0] enc(logic [31:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 32; i++)
            if (d[i]) c = c ^ cols[i];
        return c;
    endfunction

    function automatic item_t model(logic [38:0] cw);
        item_t it;
        int    found;
        logic [6:0] s;
        s = cw[38:32] ^ enc(cw[31:0]);
        it.data = cw[31:0];
        it.syn  = s;
        it.sgl  = 1'b0;
        it.dbl  = 1'b0;
        if (s != 0) begin
            found = -1;
            for (int i = 0; i < 32; i++)
                if (cols[i] == s) found = i;
            if (found >= 0) begin
                it.data[found] = ~it.data[found];
                it.sgl = 1'b1;
            end else if ($countones(s) == 1) begin
                it.sgl = 1'b1;
            end else begin
                it.dbl = 1'b1;
            end
        end
        return it;
    endfunction

    function automatic void model_zero();
        m_sgl = 0; m_dbl = 0; m2_sgl = 0; m2_dbl = 0;
        m_dsyn = '0; m_dload = 1'b0;
    endfunction

    // One clock cycle: drive at negedge, sample 1ns later, update model for the coming edge.
    task automatic tick(input bit v, input logic [38:0] d, input bit r, input bit c, input bit rs);
        @(negedge clk);
        in_vld = v; in_cw = d; out_rdy = r; cnt_clr = c; rst = rs;
        #1;
        s_in_rdy = in_rdy; s_out_vld = out_vld; s_finout = finout; s_syn = syn;
        s_err = err; s_sgl = sgl; s_dbl = dbl;
        s_sgl_cnt = sgl_cnt; s_dbl_cnt = dbl_cnt; s_dbl_syn = dbl_syn; s2_sgl_cnt = sgl_cnt2;
        e_sgl = m_sgl; e_dbl = m_dbl; e2_sgl = m2_sgl; e_dsyn = m_dsyn;
        s_out_hs = out_vld && r && !rs;
        s_in_hs = v && in_rdy && !rs;
        s_q_empty = 1'b0;
        if (s_out_hs) begin
            if (q.size() == 0) begin
                s_q_empty = 1'b1;
            end else begin
                s_exp = q.pop_front();
                if (ERRCNT) begin
                    if (s_exp.sgl && m_sgl < 65535) m_sgl++;
                    if (s_exp.sgl && m2_sgl < 3) m2_sgl++;
                    if (s_exp.dbl && m_dbl < 65535) m_dbl++;
                    if (s_exp.dbl && m2_dbl < 3) m2_dbl++;
                    if (s_exp.dbl && !m_dload) begin
                        m_dsyn = s_exp.syn;
                        m_dload = 1'b1;
                    end
                end
            end
        end
        if (c) model_zero();
        if (s_in_hs) q.push_back(model(d));
        if (rs) begin
            q.delete();
            model_zero();
        end
    endtask

    function automatic logic [38:0] rand_cw();
        logic [38:0] cw;
        int b1, b2;
        cw[31:0] = $urandom;
        cw[38:32] = enc(cw[31:0]);
        case ($urandom_range(0, 3))
            0: ;
            1: begin b1 = $urandom_range(0, 38); cw[b1] = ~cw[b1]; end
            2: begin
                b1 = $urandom_range(0, 38);
                b2 = (b1 + $urandom_range(1, 38)) % 39;
                cw[b1] = ~cw[b1]; cw[b2] = ~cw[b2];
            end
            default: cw = {$urandom, $urandom};
        endcase
        return cw;
    endfunction

    task automatic test_reset();
        tick(0, '0, 1, 0, 1);
        tick(0, '0, 1, 0, 1);
        tick(0, '0, 1, 0, 0);
        checks++;
        if (s_out_vld !== 1'b0 || s_finout !== 32'h0 || s_syn !== 7'h0 ||
            s_err !== 1'b0 || s_sgl !== 1'b0 || s_dbl !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: vld=%0b fin=%h syn=%b err=%0b sgl=%0b dbl=%0b, required all zero",
                     s_out_vld, s_finout, s_syn, s_err, s_sgl, s_dbl);
        end
        checks++;
        if (s_sgl_cnt !== 16'h0 || s_dbl_cnt !== 16'h0 || s_dbl_syn !== 7'h0) begin
            failures++;
            $display("FAIL reset_counters: sgl_cnt=%0d dbl_cnt=%0d dbl_syn=%b, required 0",
                     s_sgl_cnt, s_dbl_cnt, s_dbl_syn);
        end
        checks++;
        if (s_in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_rdy: got %0b required 1", s_in_rdy);
        end
    endtask

    task automatic test_directed();
        logic [38:0] vec  [5];
        logic [31:0] efin [5];
        logic [6:0]  esyn [5];
        bit          esgl [5];
        bit          edbl [5];
        vec[0] = 39'h0;          efin[0] = 32'h0; esyn[0] = 7'b0000000; esgl[0] = 0; edbl[0] = 0;
        vec[1] = 39'h1;          efin[1] = 32'h0; esyn[1] = 7'b0000111; esgl[1] = 1; edbl[1] = 0;
        vec[2] = 39'h1_0000_0000; efin[2] = 32'h0; esyn[2] = 7'b0000001; esgl[2] = 1; edbl[2] = 0;
        vec[3] = 39'h3;          efin[3] = 32'h3; esyn[3] = 7'b0001100; esgl[3] = 0; edbl[3] = 1;
        vec[4] = 39'h5;          efin[4] = 32'h5; esyn[4] = 7'b0001010; esgl[4] = 0; edbl[4] = 1;
        for (int k = 0; k < 5; k++) begin
            tick(1, vec[k], 1, 0, 0);
            tick(0, '0, 1, 0, 0);
            checks++;
            if (s_out_vld !== 1'b0) begin
                failures++;
                $display("FAIL latency_early[%0d]: out_vld=%0b one cycle after input, required 0", k, s_out_vld);
            end
            tick(0, '0, 1, 0, 0);
            checks++;
            if (s_out_vld !== 1'b1 || s_finout !== efin[k] || s_syn !== esyn[k] ||
                s_sgl !== esgl[k] || s_dbl !== edbl[k] || s_err !== (esgl[k] | edbl[k])) begin
                failures++;
                $display("FAIL directed[%0d]: vld=%0b fin=%h syn=%b sgl=%0b dbl=%0b err=%0b, required vld=1 fin=%h syn=%b sgl=%0b dbl=%0b",
                         k, s_out_vld, s_finout, s_syn, s_sgl, s_dbl, s_err, efin[k], esyn[k], esgl[k], edbl[k]);
            end
            $display("directed[%0d] in=%h fin=%h syn=%b sgl=%0b dbl=%0b", k, vec[k], s_finout, s_syn, s_sgl, s_dbl);
        end
        tick(0, '0, 1, 0, 0);
        checks++;
        if (s_sgl_cnt !== (ERRCNT ? 16'd2 : 16'd0) || s_dbl_cnt !== (ERRCNT ? 16'd2 : 16'd0) ||
            s_dbl_syn !== (ERRCNT ? 7'b0001100 : 7'b0)) begin
            failures++;
            $display("FAIL directed_counters: sgl_cnt=%0d dbl_cnt=%0d dbl_syn=%b, required %0d %0d %b",
                     s_sgl_cnt, s_dbl_cnt, s_dbl_syn, ERRCNT ? 2 : 0, ERRCNT ? 2 : 0,
                     ERRCNT ? 7'b0001100 : 7'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [38:0] beat [8];
        int sent, recv, cyc, start_sgl;
        bit saw_drop;
        for (int k = 0; k < 8; k++) begin
            beat[k][31:0] = $urandom;
            beat[k][38:32] = enc(beat[k][31:0]);
            beat[k][k * 4] = ~beat[k][k * 4];
        end
        sent = 0; recv = 0; cyc = 0; saw_drop = 0; start_sgl = m_sgl;
        while ((sent < 8 || recv < 8) && cyc < 60) begin
            tick(sent < 8, beat[sent < 8 ? sent : 0], !(cyc >= 4 && cyc < 7), 0, 0);
            if (s_out_vld && !(cyc >= 4 && cyc < 7) == 1'b0) begin
                saw_drop = saw_drop | !s_in_rdy;
                checks++;
                if (s_in_rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_in_rdy: cycle %0d in_rdy=%0b during stall, required 0", cyc, s_in_rdy);
                end
            end
            if (s_in_hs) sent++;
            if (s_out_hs) begin
                checks++;
                if (s_q_empty || s_finout !== s_exp.data || s_syn !== s_exp.syn ||
                    s_sgl !== s_exp.sgl || s_dbl !== s_exp.dbl) begin
                    failures++;
                    $display("FAIL b2b_beat[%0d]: fin=%h syn=%b sgl=%0b dbl=%0b extra=%0b, required fin=%h syn=%b sgl=%0b dbl=%0b",
                             recv, s_finout, s_syn, s_sgl, s_dbl, s_q_empty, s_exp.data, s_exp.syn, s_exp.sgl, s_exp.dbl);
                end
                $display("b2b beat %0d fin=%h syn=%b", recv, s_finout, s_syn);
                recv++;
            end
            cyc++;
        end
        tick(0, '0, 1, 0, 0);
        checks++;
        if (recv != 8 || sent != 8 || !saw_drop || q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count: sent=%0d recv=%0d pending=%0d rdy_drop=%0b, required 8 8 0 1",
                     sent, recv, q.size(), saw_drop);
        end
        checks++;
        if (s_sgl_cnt !== 16'(ERRCNT ? start_sgl + 8 : 0)) begin
            failures++;
            $display("FAIL b2b_sgl_cnt: got %0d required %0d", s_sgl_cnt, ERRCNT ? start_sgl + 8 : 0);
        end
    endtask

    task automatic test_random();
        bit prev_stall;
        logic [31:0] p_fin;
        logic [6:0] p_syn;
        bit p_sgl, p_dbl;
        bit r;
        prev_stall = 0; p_fin = '0; p_syn = '0; p_sgl = 0; p_dbl = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = ($urandom_range(0, 3) != 0);
            tick($urandom_range(0, 2) != 0, rand_cw(), r, 0, 0);
            if (prev_stall) begin
                checks++;
                if (s_out_vld !== 1'b1 || s_finout !== p_fin || s_syn !== p_syn ||
                    s_sgl !== p_sgl || s_dbl !== p_dbl) begin
                    failures++;
                    $display("FAIL rand_hold: cycle %0d vld=%0b fin=%h syn=%b, required held fin=%h syn=%b",
                             cyc, s_out_vld, s_finout, s_syn, p_fin, p_syn);
                end
            end
            if (s_out_hs) begin
                checks++;
                if (s_q_empty || s_finout !== s_exp.data || s_syn !== s_exp.syn ||
                    s_sgl !== s_exp.sgl || s_dbl !== s_exp.dbl || s_err !== (s_exp.sgl | s_exp.dbl)) begin
                    failures++;
                    $display("FAIL rand_beat: cycle %0d fin=%h syn=%b sgl=%0b dbl=%0b extra=%0b, required fin=%h syn=%b sgl=%0b dbl=%0b",
                             cyc, s_finout, s_syn, s_sgl, s_dbl, s_q_empty, s_exp.data, s_exp.syn, s_exp.sgl, s_exp.dbl);
                end
                $display("rand cycle %0d fin=%h syn=%b sgl=%0b dbl=%0b", cyc, s_finout, s_syn, s_sgl, s_dbl);
            end
            checks++;
            if (s_sgl_cnt !== 16'(e_sgl) || s_dbl_cnt !== 16'(e_dbl) || s_dbl_syn !== e_dsyn) begin
                failures++;
                $display("FAIL rand_counters: cycle %0d sgl=%0d dbl=%0d dsyn=%b, required %0d %0d %b",
                         cyc, s_sgl_cnt, s_dbl_cnt, s_dbl_syn, e_sgl, e_dbl, e_dsyn);
            end
            prev_stall = s_out_vld && !r;
            p_fin = s_finout; p_syn = s_syn; p_sgl = s_sgl; p_dbl = s_dbl;
        end
        for (int k = 0; k < 6; k++) begin
            tick(0, '0, 1, 0, 0);
            if (s_out_hs) begin
                checks++;
                if (s_q_empty || s_finout !== s_exp.data || s_syn !== s_exp.syn) begin
                    failures++;
                    $display("FAIL rand_drain: fin=%h syn=%b, required fin=%h syn=%b",
                             s_finout, s_syn, s_exp.data, s_exp.syn);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL rand_lost: %0d beats never emerged, required 0", q.size());
        end
    endtask

    task automatic test_clr_coincident();
        tick(1, 39'h1, 1, 0, 0);
        tick(0, '0, 1, 0, 0);
        tick(0, '0, 1, 1, 0);
        checks++;
        if (s_out_hs !== 1'b1 || s_sgl !== 1'b1) begin
            failures++;
            $display("FAIL clr_setup: out_hs=%0b sgl=%0b, required 1 1", s_out_hs, s_sgl);
        end
        tick(0, '0, 1, 0, 0);
        checks++;
        if (s_sgl_cnt !== 16'd0 || s_dbl_cnt !== 16'd0 || s_dbl_syn !== 7'd0 || e_sgl != 0) begin
            failures++;
            $display("FAIL clr_coincident: sgl_cnt=%0d dbl_cnt=%0d dbl_syn=%b, required 0 0 0",
                     s_sgl_cnt, s_dbl_cnt, s_dbl_syn);
        end
        $display("clr coincident sgl_cnt=%0d", s_sgl_cnt);
    endtask

    task automatic test_saturate();
        tick(0, '0, 1, 1, 0);
        for (int k = 0; k < 5; k++) tick(1, 39'h1 << k, 1, 0, 0);
        for (int k = 0; k < 4; k++) tick(0, '0, 1, 0, 0);
        checks++;
        if (s2_sgl_cnt !== (ERRCNT ? 2'd3 : 2'd0) || s2_sgl_cnt !== 2'(e2_sgl)) begin
            failures++;
            $display("FAIL sat_cntw2: sgl_cnt=%0d required %0d", s2_sgl_cnt, ERRCNT ? 3 : 0);
        end
        checks++;
        if (s_sgl_cnt !== (ERRCNT ? 16'd5 : 16'd0)) begin
            failures++;
            $display("FAIL sat_cntw16: sgl_cnt=%0d required %0d", s_sgl_cnt, ERRCNT ? 5 : 0);
        end
        $display("saturate cntw2=%0d cntw16=%0d", s2_sgl_cnt, s_sgl_cnt);
    endtask

    task automatic test_mid_reset();
        tick(1, rand_cw(), 1, 0, 0);
        tick(1, rand_cw(), 1, 0, 0);
        tick(0, '0, 1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            tick(0, '0, 1, 0, 0);
            checks++;
            if (s_out_vld !== 1'b0 || s_in_rdy !== 1'b1) begin
                failures++;
                $display("FAIL mid_reset[%0d]: out_vld=%0b in_rdy=%0b, required 0 1", k, s_out_vld, s_in_rdy);
            end
        end
        checks++;
        if (s_sgl_cnt !== 16'd0 || s_dbl_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset_cnt: sgl=%0d dbl=%0d, required 0 0", s_sgl_cnt, s_dbl_cnt);
        end
        $display("mid reset out_vld=%0b", s_out_vld);
    endtask

    initial begin
        build_model();
        model_zero();
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_clr_coincident();
        test_saturate();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
